// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the RV32 load/store port: byte/half/word access with lane steering and extension.
// Latency: request accepted at edge N -> resp_valid high after edge N+WAIT_CYCLES+1.
// Backpressure: one request in flight; req_ready low until the response is taken; response held stable while resp_ready=0.
module riscv_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          AW         = $clog2(4 * DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
  // The counter holds the remaining cycles including the access cycle, so
  // WAIT is always visited at least once and the latency is WAIT_CYCLES+1.
  localparam logic [4:0]  CNT_INIT   = 5'(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic          lat_we;
  logic [1:0]    lat_size;
  logic          lat_unsigned;
  logic          lat_err;
  logic [4:0]    cnt;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          access;
  logic          req_err;
  logic [AW-3:0] widx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [31:0]   load_val;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign accept = req_valid && (state == S_IDLE);
  assign access = (state == S_WAIT) && (cnt == 5'd1);
  assign widx   = lat_addr[AW-1:2];
  assign lane   = lat_addr[1:0];
  assign rd_word = mem[widx];

  // Classify the incoming request: alignment, illegal size, full 32-bit range check.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) begin
      req_err = 1'b1;
    end
  end

  // Load extraction: pick the lane(s) and sign/zero extend.
  always_comb begin
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (lat_size)
      2'b00:   load_val = {{24{~lat_unsigned & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~lat_unsigned & half_sel[15]}}, half_sel};
      default: load_val = rd_word;
    endcase
  end

  // Store merge: replace only the addressed lanes of the current word.
  always_comb begin
    wr_word = rd_word;
    case (lat_size)
      2'b00: wr_word[{lane, 3'b000} +: 8] = lat_wdata[7:0];
      2'b01: begin
        if (lane[1]) begin
          wr_word[31:16] = lat_wdata[15:0];
        end else begin
          wr_word[15:0] = lat_wdata[15:0];
        end
      end
      default: wr_word = lat_wdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 5'd1) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_err      <= 1'b0;
      cnt          <= '0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr     <= req_addr[AW-1:0];
        lat_wdata    <= req_wdata;
        lat_we       <= req_we;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_err      <= req_err;
        cnt          <= CNT_INIT;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 5'd1;
      end
      if (access) begin
        resp_err   <= lat_err;
        resp_rdata <= (lat_err || lat_we) ? 32'd0 : load_val;
      end
    end
  end

  // Memory array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (access && lat_we && !lat_err) begin
      mem[widx] <= wr_word;
    end
  end

endmodule
